// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types for the pipeline hazard sequencer
package hazard_ctrl_pkg;

    typedef logic [63:0] addr_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        TRAP = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard request inputs and pipeline control outputs
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import hazard_ctrl_pkg::*;

    logic             bubble_rs1;
    logic             bubble_rs2;
    logic             imem_busy;
    logic             dmem_busy;
    logic             md_busy;
    logic             br_taken;
    addr_t            br_target;
    logic             trap_valid;
    addr_t            trap_target;
    logic             stall_f;
    logic             stall_d;
    logic             stall_e;
    logic             stall_m;
    logic             flush_d;
    logic             flush_e;
    logic             flush_w;
    logic             redirect_valid;
    addr_t            redirect_pc;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output bubble_rs1, bubble_rs2, imem_busy, dmem_busy, md_busy,
               br_taken, br_target, trap_valid, trap_target,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
               redirect_valid, redirect_pc, stall_cnt, flush_cnt
    );

    modport slave (
        input  bubble_rs1, bubble_rs2, imem_busy, dmem_busy, md_busy,
               br_taken, br_target, trap_valid, trap_target,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
               redirect_valid, redirect_pc, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// rtl/hazard_ctrl_sat_counter.sv - saturating event counter
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline stall/flush sequencer with buffered fetch redirect
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    hazard_ctrl_if.slave      bus
);

    hz_state_t state_q, state_d;
    addr_t     pend_pc_q, pend_pc_d;
    hz_ctrl_t  ctrl;
    logic      redirect_valid;
    addr_t     redirect_pc;
    logic      flush_inc;

    always_comb begin
        ctrl           = CTRL_NONE;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        flush_inc      = 1'b0;
        state_d        = state_q;
        pend_pc_d      = pend_pc_q;

        if (bus.trap_valid) begin
            // Trap discards whatever redirect was pending.
            ctrl.flush_d   = 1'b1;
            ctrl.flush_e   = 1'b1;
            ctrl.flush_w   = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = bus.trap_target;
            flush_inc      = 1'b1;
            if (bus.imem_busy) begin
                pend_pc_d = bus.trap_target;
                state_d   = PEND;
            end else begin
                state_d   = TRAP;
            end
        end else begin
            if (bus.dmem_busy) begin
                ctrl.stall_f = 1'b1;
                ctrl.stall_d = 1'b1;
                ctrl.stall_e = 1'b1;
                ctrl.stall_m = 1'b1;
                ctrl.flush_w = 1'b1;
            end else if (bus.md_busy) begin
                // EX emits an invalid op into EX-MEM itself, so no flush_e here.
                ctrl.stall_f = 1'b1;
                ctrl.stall_d = 1'b1;
                ctrl.stall_e = 1'b1;
            end else if (bus.br_taken && (state_q != PEND)) begin
                ctrl.flush_d   = 1'b1;
                ctrl.flush_e   = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = bus.br_target;
                flush_inc      = 1'b1;
                if (bus.imem_busy) begin
                    pend_pc_d = bus.br_target;
                    state_d   = PEND;
                end
            end else if ((bus.bubble_rs1 || bus.bubble_rs2) && (state_q != PEND)) begin
                ctrl.stall_f = 1'b1;
                ctrl.stall_d = 1'b1;
                ctrl.flush_e = 1'b1;
            end

            case (state_q)
                PEND: begin
                    ctrl.flush_d   = 1'b1;
                    redirect_valid = 1'b1;
                    redirect_pc    = pend_pc_q;
                    if (!bus.imem_busy) begin
                        state_d = RUN;
                    end
                end
                TRAP: begin
                    ctrl.flush_d = 1'b1;
                    if (state_d == TRAP) begin
                        state_d = RUN;
                    end
                end
                default: ;
            endcase
        end

        if (!resetn) begin
            ctrl           = CTRL_NONE;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
            flush_inc      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= RUN;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign bus.stall_f        = ctrl.stall_f;
    assign bus.stall_d        = ctrl.stall_d;
    assign bus.stall_e        = ctrl.stall_e;
    assign bus.stall_m        = ctrl.stall_m;
    assign bus.flush_d        = ctrl.flush_d;
    assign bus.flush_e        = ctrl.flush_e;
    assign bus.flush_w        = ctrl.flush_w;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (ctrl.stall_f),
        .cnt    (bus.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (flush_inc),
        .cnt    (bus.flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard testbench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    // Expected control vector bit order: {sf, sd, se, sm, fd, fe, fw, rv}
    localparam logic [7:0] E_NONE = 8'b0000_0000;
    localparam logic [7:0] E_LU   = 8'b1100_0100;
    localparam logic [7:0] E_DMEM = 8'b1111_0010;
    localparam logic [7:0] E_MD   = 8'b1110_0000;
    localparam logic [7:0] E_BR   = 8'b0000_1101;
    localparam logic [7:0] E_PEND = 8'b0000_1001;
    localparam logic [7:0] E_TRAP = 8'b0000_1111;
    localparam logic [7:0] E_TFL  = 8'b0000_1000;

    typedef struct {
        logic [7:0]  ctrl;
        logic [63:0] pc;
    } exp_t;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;
    exp_t sb[$];

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.CNT_W(CNT_W)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] observed();
        return {bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m,
                bus.flush_d, bus.flush_e, bus.flush_w, bus.redirect_valid};
    endfunction

    task automatic idle_inputs();
        bus.bubble_rs1  = 1'b0;
        bus.bubble_rs2  = 1'b0;
        bus.imem_busy   = 1'b0;
        bus.dmem_busy   = 1'b0;
        bus.md_busy     = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_target   = '0;
        bus.trap_valid  = 1'b0;
        bus.trap_target = '0;
    endtask

    // Inputs are already driven; push expectation, sample mid-cycle, then advance past the edge.
    task automatic run_cycle(input string name, input logic [7:0] ectrl, input logic [63:0] epc);
        exp_t e;
        exp_t got;
        e.ctrl = ectrl;
        e.pc   = epc;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        checks++;
        if (observed() !== got.ctrl) begin
            failures++;
            $display("FAIL %s ctrl: got %b expected %b", name, observed(), got.ctrl);
        end
        if (got.ctrl[0]) begin
            checks++;
            if (bus.redirect_pc !== got.pc) begin
                failures++;
                $display("FAIL %s redirect_pc: got %h expected %h", name, bus.redirect_pc, got.pc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (observed() !== E_NONE || bus.stall_cnt !== '0 || bus.flush_cnt !== '0) begin
            failures++;
            $display("FAIL reset_state: ctrl %b stall_cnt %0d flush_cnt %0d expected all 0",
                     observed(), bus.stall_cnt, bus.flush_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        apply_reset();
        bus.bubble_rs1 = 1'b1;
        run_cycle("load_use", E_LU, '0);
        bus.bubble_rs1 = 1'b0;
        run_cycle("load_use_after", E_NONE, '0);
        checks++;
        if (bus.stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL load_use_stall_cnt: got %0d expected 1", bus.stall_cnt);
        end
    endtask

    task automatic test_branch_busy();
        apply_reset();
        bus.br_taken  = 1'b1;
        bus.br_target = 64'h8000_0040;
        bus.imem_busy = 1'b1;
        run_cycle("br_busy_c1", E_BR, 64'h8000_0040);
        bus.br_taken  = 1'b0;
        bus.br_target = '0;
        run_cycle("br_busy_c2", E_PEND, 64'h8000_0040);
        run_cycle("br_busy_c3", E_PEND, 64'h8000_0040);
        bus.imem_busy = 1'b0;
        run_cycle("br_busy_c4", E_PEND, 64'h8000_0040);
        run_cycle("br_busy_done", E_NONE, '0);
        checks++;
        if (bus.flush_cnt !== 4'd1 || bus.stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL br_busy_cnt: flush_cnt %0d stall_cnt %0d expected 1 and 0",
                     bus.flush_cnt, bus.stall_cnt);
        end
    endtask

    task automatic test_dmem_vs_branch();
        apply_reset();
        bus.br_taken  = 1'b1;
        bus.br_target = 64'h0000_0200;
        bus.dmem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_cycle("dmem_stall", E_DMEM, '0);
        end
        bus.dmem_busy = 1'b0;
        run_cycle("dmem_br_release", E_BR, 64'h0000_0200);
        idle_inputs();
        run_cycle("dmem_idle", E_NONE, '0);
        checks++;
        if (bus.stall_cnt !== 4'd5 || bus.flush_cnt !== 4'd1) begin
            failures++;
            $display("FAIL dmem_cnt: stall_cnt %0d flush_cnt %0d expected 5 and 1",
                     bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_md_busy();
        apply_reset();
        bus.md_busy   = 1'b1;
        bus.br_taken  = 1'b1;
        bus.br_target = 64'h0000_0300;
        run_cycle("md_stall1", E_MD, '0);
        run_cycle("md_stall2", E_MD, '0);
        bus.md_busy = 1'b0;
        run_cycle("md_br", E_BR, 64'h0000_0300);
        idle_inputs();
        run_cycle("md_idle", E_NONE, '0);
        checks++;
        if (bus.stall_cnt !== 4'd2 || bus.flush_cnt !== 4'd1) begin
            failures++;
            $display("FAIL md_cnt: stall_cnt %0d flush_cnt %0d expected 2 and 1",
                     bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_trap_override();
        apply_reset();
        bus.br_taken  = 1'b1;
        bus.br_target = 64'h0000_0100;
        bus.imem_busy = 1'b1;
        run_cycle("trap_pend_entry", E_BR, 64'h0000_0100);
        bus.br_taken    = 1'b0;
        bus.trap_valid  = 1'b1;
        bus.trap_target = 64'h8000_0000;
        run_cycle("trap_in_pend", E_TRAP, 64'h8000_0000);
        bus.trap_valid = 1'b0;
        bus.imem_busy  = 1'b0;
        run_cycle("trap_pend_drain", E_PEND, 64'h8000_0000);
        run_cycle("trap_no_reissue", E_NONE, '0);
        checks++;
        if (bus.flush_cnt !== 4'd2) begin
            failures++;
            $display("FAIL trap_flush_cnt: got %0d expected 2", bus.flush_cnt);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus.trap_valid  = 1'b1;
        bus.trap_target = 64'h0000_0040;
        run_cycle("trap_direct", E_TRAP, 64'h0000_0040);
        idle_inputs();
        run_cycle("trap_state_flush", E_TFL, '0);
        run_cycle("trap_back_run", E_NONE, '0);
        bus.bubble_rs2 = 1'b1;
        run_cycle("lu_rs2", E_LU, '0);
        bus.bubble_rs2 = 1'b0;
        run_cycle("lu_rs2_after", E_NONE, '0);
        checks++;
        if (bus.flush_cnt !== 4'd1 || bus.stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL b2b_cnt: flush_cnt %0d stall_cnt %0d expected 1 and 1",
                     bus.flush_cnt, bus.stall_cnt);
        end
    endtask

    task automatic test_reset_mid_pend();
        apply_reset();
        bus.br_taken  = 1'b1;
        bus.br_target = 64'h0000_0500;
        bus.imem_busy = 1'b1;
        run_cycle("rst_pend_entry", E_BR, 64'h0000_0500);
        bus.br_taken = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (observed() !== E_NONE || bus.redirect_pc !== '0 ||
            bus.flush_cnt !== '0 || bus.stall_cnt !== '0) begin
            failures++;
            $display("FAIL reset_async: ctrl %b pc %h flush_cnt %0d expected all 0",
                     observed(), bus.redirect_pc, bus.flush_cnt);
        end
        @(posedge clk);
        #1;
        resetn        = 1'b1;
        bus.imem_busy = 1'b0;
        run_cycle("reset_pend_lost", E_NONE, '0);
    endtask

    task automatic test_saturation();
        apply_reset();
        bus.dmem_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            run_cycle("sat_stall", E_DMEM, '0);
        end
        idle_inputs();
        run_cycle("sat_idle", E_NONE, '0);
        checks++;
        if (bus.stall_cnt !== 4'hF) begin
            failures++;
            $display("FAIL saturation: stall_cnt got %h expected F", bus.stall_cnt);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        idle_inputs();
        test_reset();
        test_load_use();
        test_branch_busy();
        test_dmem_vs_branch();
        test_md_busy();
        test_trap_override();
        test_back_to_back();
        test_reset_mid_pend();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
